// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Bridges a single-outstanding pipeline load/store request onto a word-wide
//   synchronous data memory. Sub-word stores are done as read-modify-write.
//   Little-endian byte lanes.
//
// Configuration macro:
//   LSU_MISALIGN_TRAP_EN  defined   : misaligned half/word accesses issue no
//                                     memory access and respond with
//                                     resp_error=1, resp_rdata=0.
//                         undefined : misalignment is never flagged;
//                                     low address bits below the access size
//                                     are ignored.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid / req_ready      request handshake (ready only in IDLE)
//   req_write, req_size,       access type, size (00 B, 01 H, 1x W),
//   req_signed                 load sign-extension select
//   req_addr, req_wdata        byte address, right-justified store data
//   resp_valid / resp_rdata /  one-cycle completion pulse, extended load
//   resp_error                 data, misalignment flag
//   mem_address                word index (latched addr >> 2)
//   mem_read_en / mem_write_en memory strobes, one cycle each
//   mem_data_out / mem_data_in memory write / read data
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [31:0]           mem_data_out,
  input  logic [31:0]           mem_data_in
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      r_state;
  logic [1:0]  r_lane;    // latched addr[1:0]
  logic [1:0]  r_size;
  logic        r_signed;
  logic        r_write;
  logic [15:0] r_wdata;   // only sub-word stores need the data after accept

  logic w_accept;
  logic w_misalign;
  logic w_needs_read;

  assign w_accept     = req_valid && req_ready;
  // Loads and sub-word stores both go through READ; only word stores skip it.
  assign w_needs_read = !req_write || !req_size[1];

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Pick the addressed lane out of a memory word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size,
                                               input logic        sext);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   load_extract = {{24{sext & b[7]}}, b};
      2'b01:   load_extract = {{16{sext & h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

  // Replace the addressed lane(s) of a memory word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [15:0] wdata,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size);
    logic [31:0] m;
    m = word;
    if (size == 2'b00) m[{lane, 3'b000} +: 8]     = wdata[7:0];
    else               m[{lane[1], 4'b0000} +: 16] = wdata;
    store_merge = m;
  endfunction

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_lane       <= '0;
      r_size       <= '0;
      r_signed     <= 1'b0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_error   <= 1'b0;
      mem_address  <= '0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      mem_data_out <= '0;
    end else begin
      // NOTE: strobes default low each cycle; only the branch entering the
      // matching state raises them, which yields exact one-cycle pulses.
      resp_valid   <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_lane      <= req_addr[1:0];
            r_size      <= req_size;
            r_signed    <= req_signed;
            r_write     <= req_write;
            r_wdata     <= req_wdata[15:0];
            mem_address <= req_addr >> 2;
            req_ready   <= 1'b0;
            if (w_misalign) begin
              r_state    <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else if (w_needs_read) begin
              r_state     <= READ;
              mem_read_en <= 1'b1;
            end else begin
              r_state      <= WRITE;
              mem_write_en <= 1'b1;
              mem_data_out <= req_wdata;
            end
          end
        end

        READ: begin
          if (r_write) begin
            r_state      <= WRITE;
            mem_write_en <= 1'b1;
            mem_data_out <= store_merge(mem_data_in, r_wdata, r_lane, r_size);
          end else begin
            r_state    <= RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= load_extract(mem_data_in, r_lane, r_size, r_signed);
          end
        end

        WRITE: begin
          r_state    <= RESP;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= '0;
        end

        RESP: begin
          r_state   <= IDLE;
          req_ready <= 1'b1;
        end

        default: begin
          r_state   <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Self-checking bench for load_store_unit. A byte-addressed reference
//   memory predicts load data, memory write words, latencies and strobe
//   counts; a 16-word memory model answers the DUT's memory port.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;

  logic [31:0] mem_words [16];   // memory seen by the DUT
  logic [7:0]  ref_mem   [64];   // reference byte memory

  int n_cmp    = 0;
  int n_err    = 0;
  int n_req    = 0;
  int n_accept = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .mem_address  (mem_address),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in)
  );

  assign mem_data_in = mem_words[mem_address[3:0]];

  always @(posedge clk) begin
    if (mem_write_en) mem_words[mem_address[3:0]] <= mem_data_out;
  end

  always @(posedge clk) begin
    if (!reset && req_valid && req_ready) n_accept++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    int n;
    n = nbytes(sz);
    return TRAP && ((int'(a[1:0]) % n) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg,
                                             input logic [31:0] a);
    int n, base;
    logic [31:0] v;
    n    = nbytes(sz);
    base = int'(a[5:0]) & ~(n - 1);
    v    = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
    if (sg && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd);
    int n, base;
    n    = nbytes(sz);
    base = int'(a[5:0]) & ~(n - 1);
    for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8 * i +: 8];
  endtask

  function automatic logic [31:0] model_word(input int idx);
    return {ref_mem[4 * idx + 3], ref_mem[4 * idx + 2],
            ref_mem[4 * idx + 1], ref_mem[4 * idx]};
  endfunction

  // One request, req_valid held high until the response is seen.
  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] obs);
    logic        err;
    logic [31:0] exp_rdata, exp_word;
    int          exp_lat, exp_rd, exp_wr, lat, rd, wrn, guard;
    bit          seen;
    err       = model_err(sz, a);
    exp_rdata = (wr || err) ? 32'd0 : model_load(sz, sg, a);
    exp_lat   = err ? 1 : (wr && nbytes(sz) < 4) ? 3 : 2;
    exp_rd    = (!err && (!wr || nbytes(sz) < 4)) ? 1 : 0;
    exp_wr    = (!err && wr) ? 1 : 0;
    if (wr && !err) model_store(sz, a, wd);
    exp_word  = model_word(int'(a[5:2]));
    obs       = '0;

    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    n_req++;

    lat = 0; rd = 0; wrn = 0; seen = 0;
    for (int c = 1; c <= 6 && !seen; c++) begin
      @(negedge clk);
      check({tag, " rd&wr"}, 32'(mem_read_en & mem_write_en), 32'd0);
      if (mem_read_en || mem_write_en) check({tag, " addr"}, mem_address, a >> 2);
      if (mem_read_en) rd++;
      if (mem_write_en) begin
        wrn++;
        check({tag, " wdata"}, mem_data_out, exp_word);
      end
      if (resp_valid) begin
        seen = 1;
        lat  = c;
        obs  = resp_rdata;
        check({tag, " rdata"}, resp_rdata, exp_rdata);
        check({tag, " error"}, 32'(resp_error), 32'(err));
      end
    end
    req_valid = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " reads"}, 32'(rd), 32'(exp_rd));
    check({tag, " writes"}, 32'(wrn), 32'(exp_wr));
    check({tag, " accepts"}, 32'(n_accept), 32'(n_req));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] obs;
    logic [31:0] wd;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst ready",     32'(req_ready),    32'd1);
    check("rst resp_valid", 32'(resp_valid),  32'd0);
    check("rst rdata",     resp_rdata,        32'd0);
    check("rst error",     32'(resp_error),   32'd0);
    check("rst read_en",   32'(mem_read_en),  32'd0);
    check("rst write_en",  32'(mem_write_en), 32'd0);
    check("rst address",   mem_address,       32'd0);
    check("rst data_out",  mem_data_out,      32'd0);
    reset = 1'b0;

    // fill memory through the DUT
    for (int i = 0; i < 16; i++) do_req("init", 1'b1, 2'b10, 1'b0, 32'(4 * i), $urandom, obs);

    do_req("st_w 0x10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, obs);
    do_req("ld_bs 0x13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, obs);
    check("ld_bs 0x13 const", obs, 32'hFFFFFFDE);
    do_req("ld_hu 0x10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, obs);
    check("ld_hu 0x10 const", obs, 32'h0000BEEF);
    do_req("st_b 0x11", 1'b1, 2'b00, 1'b0, 32'h11, 32'hCAFE0055, obs);
    do_req("ld_w 0x10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, obs);
    check("ld_w 0x10 const", obs, 32'hDEAD55EF);
    do_req("ld_hs 0x12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, obs);
    check("ld_hs 0x12 const", obs, 32'hFFFFDEAD);
    do_req("ld_w 0x12", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, obs);
    do_req("st_h 0x13", 1'b1, 2'b01, 1'b0, 32'h13, 32'h00008001, obs);
    do_req("ld_sz3 0x10", 1'b0, 2'b11, 1'b1, 32'h10, 32'h0, obs);

    // reset in the middle of a word store's WRITE cycle
    wd = $urandom;
    model_store(2'b10, 32'h3C, wd);   // the enabled cycle still completes at the reset edge
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h3C; req_wdata = wd;
    check("midrst ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    n_req++;
    @(negedge clk);
    check("midrst in WRITE", 32'(mem_write_en), 32'd1);
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    check("midrst write_en", 32'(mem_write_en), 32'd0);
    check("midrst read_en",  32'(mem_read_en),  32'd0);
    check("midrst resp",     32'(resp_valid),   32'd0);
    check("midrst ready",    32'(req_ready),    32'd1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst no resp", 32'(resp_valid), 32'd0);
    end

    // random back-to-back traffic
    for (int i = 0; i < 60; i++) begin
      do_req("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom, obs);
    end

    @(negedge clk);
    for (int i = 0; i < 16; i++) check("final mem", mem_words[i], model_word(i));
    check("total accepts", 32'(n_accept), 32'(n_req));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
